// File: rtl/fetch_stage_if.sv
// Fetch-stage port bundle: redirect/stall controls in, IF/ID register and imem address out.
// master = fetch stage, slave = surrounding core / environment.
interface fetch_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               stall;
    logic [1:0]         jmp_sel_id;
    logic [ADDR_W-1:0]  jmp_target_id;
    logic [ADDR_W-1:0]  jr_target_id;
    logic [1:0]         branch_sel_ex;
    logic               zero_ex;
    logic               gt_ex;
    logic [ADDR_W-1:0]  branch_target_ex;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_id;
    logic [ADDR_W-1:0]  pc_id;
    logic [ADDR_W-1:0]  pc_plus_id;
    logic               valid_id;
    logic               flush_ex;
    logic [31:0]        fetch_count;

    modport master (
        input  stall, jmp_sel_id, jmp_target_id, jr_target_id,
               branch_sel_ex, zero_ex, gt_ex, branch_target_ex, imem_rdata,
        output imem_addr, instr_id, pc_id, pc_plus_id, valid_id, flush_ex, fetch_count
    );

    modport slave (
        output stall, jmp_sel_id, jmp_target_id, jr_target_id,
               branch_sel_ex, zero_ex, gt_ex, branch_target_ex, imem_rdata,
        input  imem_addr, instr_id, pc_id, pc_plus_id, valid_id, flush_ex, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// PC register + IF/ID pipeline register with jump/branch redirect and flush.
// Latency: instruction at imem_addr appears on instr_id one edge later.
// Backpressure: stall freezes PC, IF/ID and fetch_count; a taken branch still redirects.
module fetch_stage #(
    parameter int                  ADDR_W    = 32,
    parameter int                  INSTR_W   = 32,
    parameter int                  PC_STEP   = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.master fif
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_seq;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_id_q;
    logic [ADDR_W-1:0]  pc_plus_q;
    logic               valid_q;
    logic [31:0]        count_q;
    logic               br_taken;
    logic               jmp_req;
    logic [ADDR_W-1:0]  jmp_dest;

    always_comb begin
        br_taken = (fif.branch_sel_ex == 2'b01 && fif.zero_ex) ||
                   (fif.branch_sel_ex == 2'b10 && fif.gt_ex);
        // Only a real, non-stalled instruction in ID may redirect; reserved select 11 is sequential.
        jmp_req  = valid_q && !fif.stall &&
                   (fif.jmp_sel_id == 2'b01 || fif.jmp_sel_id == 2'b10);
        jmp_dest = (fif.jmp_sel_id == 2'b10) ? fif.jr_target_id : fif.jmp_target_id;
        pc_seq   = pc + STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pc_id_q   <= '0;
            pc_plus_q <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else if (br_taken) begin
            pc      <= fif.branch_target_ex;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (jmp_req) begin
            pc      <= jmp_dest;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!fif.stall) begin
            pc        <= pc_seq;
            instr_q   <= fif.imem_rdata;
            pc_id_q   <= pc;
            pc_plus_q <= pc_seq;
            valid_q   <= 1'b1;
            count_q   <= count_q + 32'd1;
        end
    end

    assign fif.imem_addr   = pc;
    assign fif.instr_id    = instr_q;
    assign fif.pc_id       = pc_id_q;
    assign fif.pc_plus_id  = pc_plus_q;
    assign fif.valid_id    = valid_q;
    assign fif.fetch_count = count_q;
    // The ID instruction is wrong-path whenever EX resolves a taken branch.
    assign fif.flush_ex    = br_taken && !rst;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan walk plus random redirects/stalls vs a behavioural model.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) fif ();

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign fif.imem_rdata = rom(fif.imem_addr);

    fetch_stage #(
        .ADDR_W(32), .INSTR_W(32), .PC_STEP(4), .RESET_PC(32'h0), .NOP_INSTR(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    int tests = 0;
    int fails = 0;

    // Architectural view of the stage
    logic [31:0] m_pc, m_instr, m_pcid, m_pcplus, m_count;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0;
        fif.stall = 1'b0;
        fif.jmp_sel_id = 2'b00;
        fif.jmp_target_id = 32'h0;
        fif.jr_target_id = 32'h0;
        fif.branch_sel_ex = 2'b00;
        fif.zero_ex = 1'b0;
        fif.gt_ex = 1'b0;
        fif.branch_target_ex = 32'h0;
    endtask

    // One clock: check flush_ex before the edge, advance the model, compare registered outputs after it.
    task automatic tick();
        logic taken, jump;
        #1;
        taken = (fif.branch_sel_ex == 2'd1 && fif.zero_ex) || (fif.branch_sel_ex == 2'd2 && fif.gt_ex);
        jump  = m_valid && !fif.stall && (fif.jmp_sel_id == 2'd1 || fif.jmp_sel_id == 2'd2);
        check("flush_ex", {31'b0, fif.flush_ex}, {31'b0, taken && !rst});
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pcid = 0; m_pcplus = 0; m_valid = 0; m_count = 0;
        end else if (taken) begin
            m_pc = fif.branch_target_ex; m_instr = 0; m_valid = 0;
        end else if (jump) begin
            m_pc = (fif.jmp_sel_id == 2'd1) ? fif.jmp_target_id : fif.jr_target_id;
            m_instr = 0; m_valid = 0;
        end else if (!fif.stall) begin
            m_instr = rom(m_pc); m_pcid = m_pc; m_pcplus = m_pc + 4;
            m_pc = m_pc + 4; m_valid = 1; m_count = m_count + 1;
        end
        @(posedge clk);
        #1;
        check("imem_addr", fif.imem_addr, m_pc);
        check("valid_id", {31'b0, fif.valid_id}, {31'b0, m_valid});
        check("instr_id", fif.instr_id, m_instr);
        check("fetch_count", fif.fetch_count, m_count);
        if (m_valid) begin
            check("pc_id", fif.pc_id, m_pcid);
            check("pc_plus_id", fif.pc_plus_id, m_pcplus);
        end
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pcid = 0; m_pcplus = 0; m_valid = 0; m_count = 0;
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        tick();
        check("rst_addr", fif.imem_addr, 32'h0);
        check("rst_valid", {31'b0, fif.valid_id}, 32'h0);
        check("rst_count", fif.fetch_count, 32'h0);

        // Free run
        rst = 1'b0;
        tick();
        check("run1_instr", fif.instr_id, 32'h1000_0000);
        check("run1_addr", fif.imem_addr, 32'h4);
        check("run1_valid", {31'b0, fif.valid_id}, 32'h1);
        tick();
        check("run2_addr", fif.imem_addr, 32'h8);
        check("run2_instr", fif.instr_id, 32'h1000_0001);

        // Stall at imem_addr=8
        fif.stall = 1'b1;
        tick(); tick();
        check("stall_addr", fif.imem_addr, 32'h8);
        check("stall_instr", fif.instr_id, 32'h1000_0001);
        check("stall_count", fif.fetch_count, 32'd2);
        fif.stall = 1'b0;
        tick();
        check("release_instr", fif.instr_id, 32'h1000_0002);
        tick();
        check("count4", fif.fetch_count, 32'd4);

        // JMP to 0x40
        fif.jmp_sel_id = 2'b01; fif.jmp_target_id = 32'h40;
        tick();
        check("jmp_addr", fif.imem_addr, 32'h40);
        check("jmp_bubble", {31'b0, fif.valid_id}, 32'h0);
        fif.jmp_sel_id = 2'b00;
        tick();
        check("jmp_instr", fif.instr_id, 32'h1000_0010);
        check("jmp_pc_id", fif.pc_id, 32'h40);
        check("jmp_pc_plus", fif.pc_plus_id, 32'h44);

        // JR held off by stall
        fif.jmp_sel_id = 2'b10; fif.jr_target_id = 32'h100; fif.stall = 1'b1;
        tick(); tick();
        check("jr_stalled_addr", fif.imem_addr, 32'h44);
        fif.stall = 1'b0;
        tick();
        check("jr_addr", fif.imem_addr, 32'h100);
        fif.jmp_sel_id = 2'b00;
        tick();

        // Taken BE beats jump and stall
        fif.branch_sel_ex = 2'b01; fif.zero_ex = 1'b1; fif.branch_target_ex = 32'h80;
        fif.jmp_sel_id = 2'b01; fif.jmp_target_id = 32'h40; fif.stall = 1'b1;
        #1;
        check("br_flush", {31'b0, fif.flush_ex}, 32'h1);
        tick();
        check("br_addr", fif.imem_addr, 32'h80);
        check("br_valid", {31'b0, fif.valid_id}, 32'h0);
        set_idle();

        // BE not taken, BGT taken, reserved select
        fif.branch_sel_ex = 2'b01; fif.zero_ex = 1'b0; fif.gt_ex = 1'b1; fif.branch_target_ex = 32'h200;
        tick();
        check("be_nt_addr", fif.imem_addr, 32'h84);
        fif.branch_sel_ex = 2'b10; fif.branch_target_ex = 32'h20;
        tick();
        check("bgt_addr", fif.imem_addr, 32'h20);
        fif.branch_sel_ex = 2'b11; fif.zero_ex = 1'b1;
        tick();
        check("b11_addr", fif.imem_addr, 32'h24);
        set_idle();

        // Reset at pc=0x44 during stall
        tick();
        fif.jmp_sel_id = 2'b01; fif.jmp_target_id = 32'h44;
        tick();
        fif.jmp_sel_id = 2'b00; fif.stall = 1'b1; rst = 1'b1;
        tick();
        check("rst2_addr", fif.imem_addr, 32'h0);
        check("rst2_valid", {31'b0, fif.valid_id}, 32'h0);
        check("rst2_count", fif.fetch_count, 32'h0);
        set_idle();

        // PC wrap
        tick();
        fif.jmp_sel_id = 2'b01; fif.jmp_target_id = 32'hFFFF_FFFC;
        tick();
        fif.jmp_sel_id = 2'b00;
        tick();
        check("wrap_addr", fif.imem_addr, 32'h0);
        check("wrap_instr", fif.instr_id, 32'h4FFF_FFFF);
        check("wrap_pc_plus", fif.pc_plus_id, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            fif.stall = ($urandom_range(0, 3) == 0);
            fif.jmp_sel_id = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fif.jmp_target_id = $urandom & 32'hFFFF_FFFC;
            fif.jr_target_id = $urandom & 32'hFFFF_FFFC;
            fif.branch_sel_ex = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fif.zero_ex = 1'($urandom);
            fif.gt_ex = 1'($urandom);
            fif.branch_target_ex = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the interpolation ASIP core.
- Holds the PC and drives the instruction-memory address.
- Latches fetched instructions into IF/ID, which feeds the opcode/ALU-function decoder.
- Consumes the decoder's jump select (ID stage) and the branch select plus flags from EX, then redirects, stalls or flushes accordingly.

Parameters:
- ADDR_W, 32, PC / instruction address width.
- INSTR_W, 32, instruction word width.
- PC_STEP, 4, sequential PC increment (byte-addressed memory).
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 0, bubble word inserted on flush. All-zero decodes as ADD r0,r0,r0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hazard-unit hold request.
- jmp_sel_id  in  2  decoded jump select of the instruction in ID. 00 seq, 01 JMP, 10 JR, 11 reserved (treated as 00).
- jmp_target_id  in  ADDR_W  JMP absolute target.
- jr_target_id  in  ADDR_W  JR register-sourced target.
- branch_sel_ex  in  2  branch select of the instruction in EX. 00 none, 01 BE, 10 BGT, 11 reserved (never taken).
- zero_ex  in  1  ALU zero flag for the instruction in EX.
- gt_ex  in  1  ALU greater-than flag for the instruction in EX.
- branch_target_ex  in  ADDR_W  branch target computed in EX.
- imem_addr  out  ADDR_W  equals the PC register; instruction ROM reads combinationally.
- imem_rdata  in  INSTR_W  instruction word at imem_addr, valid in the same cycle.
- instr_id  out  INSTR_W  IF/ID instruction to the decoder.
- pc_id  out  ADDR_W  address of instr_id.
- pc_plus_id  out  ADDR_W  pc_id+PC_STEP, used as the CALL link value.
- valid_id  out  1  instr_id is a real instruction (0 means bubble).
- flush_ex  out  1  combinational; kill the instruction currently leaving ID.
- fetch_count  out  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, instr_id=NOP_INSTR, pc_id=0, pc_plus_id=0, valid_id=0, fetch_count=0.
  - flush_ex forced 0 while rst=1.
  - Reset overrides all other inputs, including mid-redirect or mid-stall.
- br_taken = (branch_sel_ex==01 & zero_ex) | (branch_sel_ex==10 & gt_ex).
- jmp_req = valid_id & ~stall & (jmp_sel_id==01 | jmp_sel_id==10).
- Per-edge priority, highest first:
  1. br_taken:
     - pc <= branch_target_ex.
     - IF/ID <= {NOP_INSTR, valid 0}; fetch_count holds.
     - flush_ex=1 in this cycle.
     - Overrides stall and jmp_req, since the ID instruction is wrong-path.
  2. jmp_req:
     - pc <= jmp_target_id (01) or jr_target_id (10).
     - IF/ID <= bubble (valid 0); fetch_count holds; flush_ex=0, because the jump itself proceeds to EX.
  3. stall:
     - pc, IF/ID and fetch_count hold.
     - A jump in ID waits and redirects on the first non-stall cycle.
  4. Otherwise:
     - pc <= pc+PC_STEP, wrapping modulo 2^ADDR_W.
     - instr_id <= imem_rdata; pc_id <= pc; pc_plus_id <= pc+PC_STEP; valid_id <= 1.
     - fetch_count += 1, wrapping at 2^32.
- Latency: an instruction at address A appears on instr_id one cycle after imem_addr==A.
- Redirect penalty:
  - Jump: 1 bubble.
  - Taken branch: 1 bubble in IF/ID plus the flushed ID slot.
- Redirect to the current PC is legal and behaves as an ordinary redirect (bubble inserted).
- No X propagation: reserved selects behave as defined above.

Test Plan:
- Reset, then free-run with ROM[A]=0x10000000+A/4:
  - imem_addr = 0, 4, 8, 12.
  - instr_id = 0x10000000, 0x10000001, ... one cycle later.
  - valid_id=1 from the first post-reset edge; fetch_count=4 after 4 edges.
- stall=1 for 2 cycles while imem_addr=8:
  - imem_addr stays 8; instr_id holds 0x10000001; fetch_count frozen.
  - Release: next instr_id=0x10000002.
- ID holds valid JMP (jmp_sel_id=01, target 0x40):
  - Next imem_addr=0x40; valid_id=0 for 1 cycle.
  - Then instr_id=ROM[0x40] with pc_id=0x40, pc_plus_id=0x44.
- JR (jmp_sel_id=10, jr_target 0x100) with stall=1 for 2 cycles:
  - No redirect while stalled.
  - imem_addr=0x100 after the first edge with stall=0.
- branch_sel_ex=01, zero_ex=1, target 0x80, with simultaneous jmp_sel_id=01 (target 0x40) and stall=1:
  - flush_ex=1; pc -> 0x80; valid_id=0.
- Branch flag cases:
  - BE with zero_ex=0: no redirect.
  - BGT with gt_ex=1, target 0x20: pc -> 0x20.
  - branch_sel_ex=11: never taken.
- Reset and wrap:
  - rst asserted at pc=0x44 during a stall: next edge pc=0, valid_id=0, fetch_count=0.
  - Preload pc=0xFFFFFFFC via JMP: next sequential pc=0x00000000.
